// File: rtl/params_loader.sv
// Parameter loader: copies a 32-entry shadow table to an Avalon-MM slave.
// Optional readback verify is compiled in with `define PARAMS_LOADER_VERIFY_EN.
module params_loader #(
  parameter int          NUM_WORDS   = 21,
  parameter int          ADDR_W      = 21,
  parameter logic [31:0] VERIFY_MASK = 32'h001C_FFFE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [4:0]        cfg_idx,
  input  logic [31:0]       cfg_data,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] avm_m0_address,
  output logic [31:0]       avm_m0_writedata,
  output logic              avm_m0_write,
  output logic              avm_m0_read,
  input  logic [31:0]       avm_m0_readdata,
  input  logic              avm_m0_waitrequest,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              err,
  output logic [4:0]        err_idx
);

  typedef enum logic [2:0] {IDLE, WR, RD, CMP, FIN} state_t;

  state_t      state;
  logic [4:0]  idx;
  logic        abort_pend;
  logic [31:0] shadow [32];

  logic       last;
  logic       abort_now;
  logic [4:0] idx_nxt;

  assign last      = (idx == 5'(NUM_WORDS - 1));
  assign abort_now = abort | abort_pend;
  assign idx_nxt   = idx + 5'd1;

  // No reset on the table: contents are undefined until software writes them.
  always_ff @(posedge clk) begin
    if (cfg_we && !busy)
      shadow[cfg_idx] <= cfg_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      idx              <= '0;
      abort_pend       <= 1'b0;
      avm_m0_address   <= '0;
      avm_m0_writedata <= '0;
      avm_m0_write     <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      aborted          <= 1'b0;
`ifdef PARAMS_LOADER_VERIFY_EN
      avm_m0_read      <= 1'b0;
      err              <= 1'b0;
      err_idx          <= '0;
`endif
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state            <= WR;
            idx              <= '0;
            abort_pend       <= 1'b0;
            busy             <= 1'b1;
            avm_m0_write     <= 1'b1;
            avm_m0_address   <= '0;
            avm_m0_writedata <= shadow[0];
`ifdef PARAMS_LOADER_VERIFY_EN
            err              <= 1'b0;
`endif
          end
        end
        WR: begin
          if (!avm_m0_waitrequest) begin
            avm_m0_write <= 1'b0;
            if (abort_now) begin
              state      <= IDLE;
              busy       <= 1'b0;
              aborted    <= 1'b1;
              abort_pend <= 1'b0;
`ifdef PARAMS_LOADER_VERIFY_EN
            end else if (VERIFY_MASK[idx]) begin
              state       <= RD;
              avm_m0_read <= 1'b1;
`endif
            end else if (last) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state            <= WR;
              idx              <= idx_nxt;
              avm_m0_write     <= 1'b1;
              avm_m0_address   <= ADDR_W'(idx_nxt);
              avm_m0_writedata <= shadow[idx_nxt];
            end
          end else if (abort) begin
            abort_pend <= 1'b1;
          end
        end
`ifdef PARAMS_LOADER_VERIFY_EN
        RD: begin
          if (!avm_m0_waitrequest) begin
            avm_m0_read <= 1'b0;
            if (abort_now) begin
              state      <= IDLE;
              busy       <= 1'b0;
              aborted    <= 1'b1;
              abort_pend <= 1'b0;
            end else begin
              state <= CMP;
            end
          end else if (abort) begin
            abort_pend <= 1'b1;
          end
        end
        CMP: begin
          if (!err && (avm_m0_readdata != shadow[idx])) begin
            err     <= 1'b1;
            err_idx <= idx;
          end
          if (abort_now) begin
            state      <= IDLE;
            busy       <= 1'b0;
            aborted    <= 1'b1;
            abort_pend <= 1'b0;
          end else if (last) begin
            state <= FIN;
            done  <= 1'b1;
          end else begin
            state            <= WR;
            idx              <= idx_nxt;
            avm_m0_write     <= 1'b1;
            avm_m0_address   <= ADDR_W'(idx_nxt);
            avm_m0_writedata <= shadow[idx_nxt];
          end
        end
`endif
        FIN: begin
          state      <= IDLE;
          busy       <= 1'b0;
          abort_pend <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifndef PARAMS_LOADER_VERIFY_EN
  logic unused_verify;
  assign unused_verify = ^{VERIFY_MASK, avm_m0_readdata};
  assign avm_m0_read   = 1'b0;
  assign err           = 1'b0;
  assign err_idx       = '0;
`endif

endmodule

// File: tb/tb_params_loader.sv
// Directed self-checking bench for params_loader (default build; verify
// scenario runs instead when PARAMS_LOADER_VERIFY_EN is defined).
module tb_params_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cfg_we = 1'b0;
  logic [4:0]  cfg_idx = '0;
  logic [31:0] cfg_data = '0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [20:0] address;
  logic [31:0] writedata;
  logic        write_req;
  logic        read_req;
  logic [31:0] readdata;
  logic        waitreq = 1'b0;
  logic        busy, done, aborted, err;
  logic [4:0]  err_idx;

  int pass_cnt  = 0;
  int total_cnt = 0;
  bit seen;

  always #5 clk = ~clk;

  params_loader dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_data(cfg_data),
    .start(start), .abort(abort),
    .avm_m0_address(address), .avm_m0_writedata(writedata),
    .avm_m0_write(write_req), .avm_m0_read(read_req),
    .avm_m0_readdata(readdata), .avm_m0_waitrequest(waitreq),
    .busy(busy), .done(done), .aborted(aborted), .err(err), .err_idx(err_idx)
  );

`ifdef PARAMS_LOADER_VERIFY_EN
  // Slave: returns what was written, except index 9 reads back as zero.
  logic [31:0] slave_mem [32];
  always @(posedge clk) begin
    if (write_req && !waitreq) slave_mem[address[4:0]] <= writedata;
    if (read_req && !waitreq)
      readdata <= (address[4:0] == 5'd9) ? 32'h0 : slave_mem[address[4:0]];
  end
`else
  assign readdata = 32'h0;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic wait_done(input int budget, output bit hit);
    hit = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        hit = 1'b1;
        break;
      end
      tick();
    end
  endtask

  initial begin
    tick();
    tick();
    chk("rst_write",   {31'b0, write_req}, 32'd0);
    chk("rst_read",    {31'b0, read_req},  32'd0);
    chk("rst_busy",    {31'b0, busy},      32'd0);
    chk("rst_done",    {31'b0, done},      32'd0);
    chk("rst_aborted", {31'b0, aborted},   32'd0);
    chk("rst_err",     {31'b0, err},       32'd0);
    chk("rst_err_idx", {27'b0, err_idx},   32'd0);
    chk("rst_address", {11'b0, address},   32'd0);
    chk("rst_wdata",   writedata,          32'd0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 21; i++) begin
      cfg_we = 1'b1; cfg_idx = 5'(i); cfg_data = 32'hA000_0000 + i;
      tick();
    end
    cfg_we = 1'b0;

`ifdef PARAMS_LOADER_VERIFY_EN
    start = 1'b1; tick(); start = 1'b0;
    wait_done(200, seen);
    chk("vfy_done_seen", {31'b0, seen},    32'd1);
    chk("vfy_err",       {31'b0, err},     32'd1);
    chk("vfy_err_idx",   {27'b0, err_idx}, 32'd9);
    tick();
    start = 1'b1; tick(); start = 1'b0;
    chk("vfy_err_clear", {31'b0, err},     32'd0);
    wait_done(200, seen);
    chk("vfy_done2",     {31'b0, seen},    32'd1);
    chk("vfy_err_idx2",  {27'b0, err_idx}, 32'd9);
    tick();
`else
    // Full load: start cycle is cycle 1, writes in cycles 2..22, done in 23.
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 21; k++) begin
      chk("full_write", {31'b0, write_req}, 32'd1);
      chk("full_addr",  {11'b0, address},   32'(k));
      chk("full_wdata", writedata,          32'hA000_0000 + k);
      chk("full_nodone", {31'b0, done},     32'd0);
      tick();
    end
    chk("full_done",      {31'b0, done},      32'd1);
    chk("full_busy_fin",  {31'b0, busy},      32'd1);
    chk("full_write_fin", {31'b0, write_req}, 32'd0);
    tick();
    chk("full_done_off",  {31'b0, done},      32'd0);
    chk("full_busy_off",  {31'b0, busy},      32'd0);
    chk("full_no_read",   {31'b0, read_req},  32'd0);
    chk("full_err",       {31'b0, err},       32'd0);

    // Stall on index 5 for three cycles.
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    waitreq = 1'b1;
    for (int r = 0; r < 4; r++) begin
      if (r == 3) waitreq = 1'b0;
      chk("stall_addr",  {11'b0, address},   32'd5);
      chk("stall_wdata", writedata,          32'hA000_0005);
      chk("stall_write", {31'b0, write_req}, 32'd1);
      tick();
    end
    chk("stall_next_addr", {11'b0, address}, 32'd6);
    wait_done(40, seen);
    chk("stall_done_seen", {31'b0, seen}, 32'd1);
    tick();

    // Abort while write at index 7 is stalled.
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    waitreq = 1'b1; abort = 1'b1;
    chk("abort_addr", {11'b0, address}, 32'd7);
    tick();
    abort = 1'b0;
    chk("abort_held_write", {31'b0, write_req}, 32'd1);
    chk("abort_held_addr",  {11'b0, address},   32'd7);
    chk("abort_no_pulse",   {31'b0, aborted},   32'd0);
    tick();
    chk("abort_held_write2", {31'b0, write_req}, 32'd1);
    waitreq = 1'b0;
    tick();
    chk("abort_pulse",    {31'b0, aborted},   32'd1);
    chk("abort_write_off",{31'b0, write_req}, 32'd0);
    chk("abort_busy_off", {31'b0, busy},      32'd0);
    chk("abort_no_done",  {31'b0, done},      32'd0);
    tick();
    chk("abort_pulse_end", {31'b0, aborted},  32'd0);
    chk("abort_no_write8", {31'b0, write_req}, 32'd0);
    chk("abort_no_done2",  {31'b0, done},     32'd0);

    // start and cfg_we while busy are both ignored.
    start = 1'b1; tick(); start = 1'b0;
    tick();
    cfg_we = 1'b1; cfg_idx = 5'd3; cfg_data = 32'hDEAD_BEEF; start = 1'b1;
    tick();
    cfg_we = 1'b0; start = 1'b0;
    chk("busy_addr_cont", {11'b0, address}, 32'd2);
    wait_done(40, seen);
    chk("busy_done_seen", {31'b0, seen}, 32'd1);
    tick();
    chk("busy_no_restart", {31'b0, busy}, 32'd0);
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    chk("busy_shadow_addr", {11'b0, address}, 32'd3);
    chk("busy_shadow_kept", writedata,        32'hA000_0003);
    wait_done(40, seen);
    chk("reload_done_seen", {31'b0, seen}, 32'd1);
    tick();

    // abort alone in IDLE does nothing.
    abort = 1'b1; tick(); abort = 1'b0;
    chk("idle_abort_busy",    {31'b0, busy},    32'd0);
    chk("idle_abort_aborted", {31'b0, aborted}, 32'd0);

    // start with abort in IDLE starts, abort is not remembered.
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    chk("sa_busy", {31'b0, busy},    32'd1);
    chk("sa_addr", {11'b0, address}, 32'd0);
    tick();
    chk("sa_addr1",     {11'b0, address}, 32'd1);
    chk("sa_noaborted", {31'b0, aborted}, 32'd0);
    tick();

    // Asynchronous reset mid-sequence.
    #2 rst = 1'b0;
    #1;
    chk("arst_write", {31'b0, write_req}, 32'd0);
    chk("arst_busy",  {31'b0, busy},      32'd0);
    chk("arst_addr",  {11'b0, address},   32'd0);
    tick();
    rst = 1'b1;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    chk("arst_restart_write", {31'b0, write_req}, 32'd1);
    chk("arst_restart_addr",  {11'b0, address},   32'd0);
    chk("arst_restart_wdata", writedata,          32'hA000_0000);
    wait_done(40, seen);
    chk("arst_done_seen", {31'b0, seen}, 32'd1);
    tick();
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
